// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-glyph decoder for the 7-segment debug display.
// Glyph bits are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Board wiring of the packed source bus.
    typedef enum logic [1:0] {
        SRC_REG = 2'd0,
        SRC_MEM = 2'd1,
        SRC_ALU = 2'd2,
        SRC_PC  = 2'd3
    } src_e;

    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_debug_view_scan.sv
// Refresh divider and digit counter; frame_end marks the last cycle of a full scan.
module seg7_scan #(
    parameter int DIGITS = 8,
    parameter int DIV_W  = 17,
    localparam int DIG_W = $clog2(DIGITS)
) (
    input  logic             clk,
    input  logic             clr,
    output logic [DIG_W-1:0] dig,
    output logic             frame_end
);

    logic [DIV_W-1:0] div;
    logic             div_wrap;
    logic             dig_last;

    assign div_wrap  = &div;
    assign dig_last  = (dig == DIG_W'(DIGITS - 1));
    assign frame_end = div_wrap && dig_last;

    always_ff @(posedge clk) begin
        if (clr) begin
            div <= '0;
            dig <= '0;
        end else begin
            div <= div + 1'b1;
            if (div_wrap)
                dig <= dig_last ? '0 : dig + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_debug_view.sv
// Multi-source debug display: address pointer, per-frame data snapshot, muxed 7-seg output.
// Auto-scroll is built only when DISP_AUTOSCROLL_EN is defined.
module seg7_debug_view
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int NSRC        = 4,
    parameter int ADDR_W      = 6,
    parameter int DIV_W       = 17,
    parameter int AUTO_FRAMES = 64
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [$clog2(NSRC)-1:0]  src_sel,
    input  logic [NSRC*32-1:0]       src_data,
    input  logic                     load,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic                     step,
    input  logic                     auto,
    output logic [ADDR_W-1:0]        read_addr,
    output logic [6:0]               a2g,
    output logic [DIGITS-1:0]        an,
    output logic                     dp
);

    localparam int DIG_W = $clog2(DIGITS);

    logic [DIG_W-1:0]  dig;
    logic              frame_end;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       snap;
    logic [31:0]       sel_data;
    logic              tick;
    logic [7:0]        ptr8;
    logic [3:0]        nib;

    seg7_scan #(
        .DIGITS (DIGITS),
        .DIV_W  (DIV_W)
    ) u_scan (
        .clk       (clk),
        .clr       (clr),
        .dig       (dig),
        .frame_end (frame_end)
    );

    // Out-of-range selects fall back to source 0.
    always_comb begin
        sel_data = src_data[31:0];
        for (int k = 1; k < NSRC; k++)
            if (int'(src_sel) == k)
                sel_data = src_data[32*k +: 32];
    end

`ifdef DISP_AUTOSCROLL_EN
    localparam int FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    logic [FC_W-1:0] fcnt;
    logic            fc_last;

    assign fc_last = (fcnt == FC_W'(AUTO_FRAMES - 1));
    assign tick    = auto && frame_end && fc_last;

    always_ff @(posedge clk) begin
        if (clr || !auto)
            fcnt <= '0;
        else if (frame_end)
            fcnt <= fc_last ? '0 : fcnt + 1'b1;
    end
`else
    logic auto_unused;
    assign auto_unused = auto | (AUTO_FRAMES < 1);
    assign tick        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr  <= '0;
            snap <= '0;
        end else begin
            if (load)
                ptr <= addr_in;
            else if (step || tick)
                ptr <= ptr + 1'b1;
            if (frame_end)
                snap <= sel_data;
        end
    end

    assign read_addr = ptr;

    // Pointer digits read the live pointer; data digits read the frame snapshot.
    always_comb begin
        ptr8             = '0;
        ptr8[ADDR_W-1:0] = ptr;
        if (dig == DIG_W'(DIGITS - 2))
            nib = ptr8[3:0];
        else if (dig == DIG_W'(DIGITS - 1))
            nib = ptr8[7:4];
        else
            nib = 4'(snap >> {dig, 2'b00});
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            an  <= '1;
            a2g <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(DIGITS'(1) << dig);
            a2g <= hex2seg(nib);
            dp  <= !(dig == DIG_W'(DIGITS - 2));
        end
    end

endmodule

// File: doc/seg7_debug_view.md
# seg7_debug_view

Parametrised multi-source debug display for the MIPS register-file board. It owns the address pointer used to read the register file, data memory or other taps, and snapshots the selected 32-bit source once per display frame. It time-multiplexes the result onto a common-anode 7-segment bank. The pointer and data are shown side by side, with optional auto-scroll through addresses.

## Interface
- `DIGITS`, default 8: number of digits, 3..8; the top two digits show the pointer.
- `NSRC`, default 4: number of 32-bit sources (0 register file, 1 memory, 2 ALU out, 3 PC by board convention).
- `ADDR_W`, default 6: pointer width, 1..8.
- `DIV_W`, default 17: refresh divider width, at least 1.
- `AUTO_FRAMES`, default 64: frames per auto-scroll step, at least 1.

Ports:
- `clk` in, 1: single clock.
- `clr` in, 1: reset, synchronous and active-high.
- `src_sel` in, `$clog2(NSRC)`: selected source; values at or above NSRC select source 0.
- `src_data` in, NSRC*32: packed sources, with source k at [32k+31:32k].
- `load` in, 1: pulse that loads `addr_in` into the pointer.
- `addr_in` in, ADDR_W: load value for the pointer.
- `step` in, 1: single-cycle pulse (already debounced) that increments the pointer.
- `auto` in, 1: auto-scroll enable.
- `read_addr` out, ADDR_W: current pointer, driven to the register-file and memory read ports.
- `a2g` out, 7: segments a..g, active-low.
- `an` out, DIGITS: digit enables, active-low, one-hot.
- `dp` out, 1: decimal point, active-low.

## Operation
- **Pointer `ptr`**
  - Priority order: `load` → `addr_in`, then `step` → ptr+1, then auto-tick → ptr+1.
  - At most one update per cycle.
  - Increment wraps from 2^ADDR_W−1 to 0.
- **Auto-tick**
  - A frame counter counts frame-end pulses while `auto`=1. When it reaches AUTO_FRAMES−1 it issues a tick and returns to 0.
  - When `auto`=0 the counter is held at 0.
- **Snapshot**
  - On every frame-end pulse: `snap` ← `src_data[src_sel]`, sampled in the same cycle.
  - The displayed data is therefore tear-free and at most one frame stale.
- **Scan**
  - `div` free-runs.
  - When `div` is all-ones, the digit index `dig` advances, wrapping from DIGITS−1 to 0.
  - Frame-end = `div` all-ones AND `dig`==DIGITS−1.
- **Digit content**
  - Digits 0..DIGITS−3 show hex nibbles of `snap`, with digit 0 as the LSB.
  - Digits DIGITS−2 and DIGITS−1 show the low and high nibbles of `ptr`, zero-extended.
  - `dp`=0 only on digit DIGITS−2 (address/data separator).
- **Outputs**: `a2g`, `an` and `dp` are registered.

## Timing
- Reset values: `ptr`=0, `div`=0, `dig`=0, frame counter=0, `snap`=0, `an`=all ones, `a2g`=7'h7F, `dp`=1.
- `read_addr` is combinational from `ptr`, so it changes the cycle after `load`/`step`. `src_data` must settle within that same cycle (asynchronous reads).
- Display outputs lag `dig` by one cycle. Each digit is held for 2^DIV_W cycles.
- Full frame = DIGITS·2^DIV_W cycles.
- A `load`/`step` issued mid-frame is visible in the pointer digits immediately. The data digits update at the next frame-end.
- `clr` mid-frame: all state returns to reset values on the next edge, and `an` is blanked for exactly one cycle.

## Configuration
- **`DISP_AUTOSCROLL_EN` defined**: auto-scroll logic is present as described above.
- **`DISP_AUTOSCROLL_EN` undefined**:
  - The frame counter and tick are removed, and `auto` is ignored.
  - `AUTO_FRAMES` is unused.
  - The pointer changes only via `load`/`step`.

## Structure
- Package `seg7_pkg`:
  - `function hex2seg(nibble) → 7-bit active-low` pattern.
  - `SEG_BLANK` = 7'h7F.
  - Default source-index constants: `SRC_REG`, `SRC_MEM`, `SRC_ALU`, `SRC_PC`.
- Sub-module `seg7_scan` (params DIGITS, DIV_W; outputs `dig`, `frame_end`): holds the divider and digit counter. The top level keeps the pointer, snapshot, auto-scroll logic and output registers.

## Test plan
Bench parameters: DIGITS=8, DIV_W=2, AUTO_FRAMES=2.
1. Reset → `an`=8'hFF, `a2g`=7'h7F, `dp`=1 and `read_addr`=0. After the first scan, `an`=8'hFE shows nibble 0 of 0, i.e. `a2g`=7'h40 (0 glyph).
2. `load` with `addr_in`=6'h3F, then `step` → `read_addr`=6'h3F, then 6'h00 (wrap). Digit 6 shows "0" with `dp`=0.
3. `src_sel`=1 with `src_data` source 1=32'h00ABCDEF, held for one frame → digits 5..0 show "ABCDEF". A change to 32'h00123456 mid-frame is not displayed until the next frame.
4. `load` and `step` in the same cycle with `addr_in`=5 → `read_addr`=5 (load wins).
5. `auto`=1 with `ptr`=0 → `read_addr` increments every 2 frames (64 cycles). `auto`=0 freezes it. With `DISP_AUTOSCROLL_EN` undefined, the pointer never moves.
6. `clr` asserted at `dig`=4 → the next cycle shows the full reset state, and the scan restarts at digit 0.
